// File: rtl/alu_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_issuer
// Description : Collects an opcode/A/B byte frame, issues it to a combinational
//               ALU and returns the result over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_issuer #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_data,
    output logic [18:0]          cmd,
    output logic                 cmd_valid,
    input  logic [7:0]           alu_result,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_data,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic [2:0] {
        S_GET_OP = 3'd0,
        S_GET_A  = 3'd1,
        S_GET_B  = 3'd2,
        S_ISSUE  = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   w_in_xfer;
    logic                   w_out_xfer;
    logic                   w_op_legal;
    logic                   r_legal;
    logic [18:0]            r_cmd;
    logic [7:0]             r_out_data;
    logic                   r_out_err;
    logic [ERR_CNT_W-1:0]   r_err_count;

    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = out_valid & out_ready;
    assign cmd        = r_cmd;
    assign out_data   = r_out_data;
    assign out_err    = r_out_err;
    assign err_count  = r_err_count;

    always_comb begin
        w_op_legal = 1'b0;
        case (in_data[2:0])
            3'b100, 3'b010, 3'b001, 3'b110, 3'b011: w_op_legal = 1'b1;
            default:                                w_op_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_GET_OP;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        cmd_valid = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_GET_OP: begin
                in_ready = 1'b1;
                if (w_in_xfer) w_next = S_GET_A;
            end
            S_GET_A: begin
                in_ready = 1'b1;
                if (w_in_xfer) w_next = S_GET_B;
            end
            S_GET_B: begin
                in_ready = 1'b1;
                // Illegal frames skip the ALU and report straight away
                if (w_in_xfer) w_next = r_legal ? S_ISSUE : S_RESP;
            end
            S_ISSUE: begin
                cmd_valid = 1'b1;
                w_next    = S_RESP;
            end
            S_RESP: begin
                out_valid = 1'b1;
                if (w_out_xfer) w_next = S_GET_OP;
            end
            default: w_next = S_GET_OP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_legal     <= 1'b0;
            r_cmd       <= '0;
            r_out_data  <= '0;
            r_out_err   <= 1'b0;
            r_err_count <= '0;
        end else begin
            if (w_in_xfer) begin
                case (r_state)
                    S_GET_OP: begin
                        r_cmd[18:16] <= in_data[2:0];
                        r_legal      <= w_op_legal;
                    end
                    S_GET_A: r_cmd[15:8] <= in_data;
                    S_GET_B: begin
                        r_cmd[7:0] <= in_data;
                        if (!r_legal) begin
                            r_out_data <= '0;
                            r_out_err  <= 1'b1;
                            if (r_err_count != {ERR_CNT_W{1'b1}}) begin
                                r_err_count <= r_err_count + ERR_CNT_W'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
            if (r_state == S_ISSUE) begin
                r_out_data <= alu_result;
                r_out_err  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_cmd_issuer
// Description : Scoreboard bench for alu_cmd_issuer with a behavioural ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_issuer;

    localparam int c_ERR_W = 2;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [7:0]         in_data;
    logic [18:0]        cmd;
    logic               cmd_valid;
    logic [7:0]         alu_result;
    logic               out_valid;
    logic               out_ready;
    logic [7:0]         out_data;
    logic               out_err;
    logic [c_ERR_W-1:0] err_count;

    alu_cmd_issuer #(.ERR_CNT_W(c_ERR_W)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_err    (out_err),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        alu_result = 8'h00;
        case (cmd[18:16])
            3'b100:  alu_result = cmd[15:8] + cmd[7:0];
            3'b010:  alu_result = cmd[15:8] - cmd[7:0];
            3'b001:  alu_result = cmd[15:8] & cmd[7:0];
            3'b110:  alu_result = cmd[15:8] | cmd[7:0];
            3'b011:  alu_result = cmd[15:8] ^ cmd[7:0];
            default: alu_result = 8'h00;
        endcase
    end

    int          n_total = 0;
    int          n_bad   = 0;
    int          pulses  = 0;
    int          resp_seen = 0;
    logic [7:0]  q_data[$];
    logic        q_err[$];
    logic [18:0] q_cmd[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmd_valid) begin
            pulses++;
            if (q_cmd.size() == 0) begin
                chk("cmd_extra", 32'd1, 32'd0);
            end else begin
                chk("cmd", {13'd0, cmd}, {13'd0, q_cmd.pop_front()});
            end
        end
        if (cmd_valid || out_valid) chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
        if (out_valid && out_ready) begin
            if (q_data.size() == 0) begin
                chk("resp_extra", 32'd1, 32'd0);
            end else begin
                chk("out_data", {24'd0, out_data}, {24'd0, q_data.pop_front()});
                chk("out_err", {31'd0, out_err}, {31'd0, q_err.pop_front()});
            end
            resp_seen++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("byte_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] exp_data, input logic exp_err);
        q_data.push_back(exp_data);
        q_err.push_back(exp_err);
        if (!exp_err) q_cmd.push_back({op[2:0], a, b});
        send_byte(op);
        send_byte(a);
        send_byte(b);
    endtask

    task automatic wait_resp(input int target);
        int n;
        n = 0;
        while (resp_seen < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (resp_seen < target) chk("resp_timeout", resp_seen, target);
        @(posedge clk);
        #1;
    endtask

    int          p0;
    logic [1:0]  exp_cnt;
    logic [7:0]  sat_ops[5];

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        exp_cnt   = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_cmd", {13'd0, cmd}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADD with latency checks
        p0 = pulses;
        send_frame(8'h04, 8'h03, 8'h05, 8'h08, 1'b0);
        chk("add_issue_cv", {31'd0, cmd_valid}, 32'd1);
        chk("add_issue_ov", {31'd0, out_valid}, 32'd0);
        chk("add_cmd", {13'd0, cmd}, 32'h40305);
        @(posedge clk);
        #1;
        chk("add_ov_rise", {31'd0, out_valid}, 32'd1);
        chk("add_data", {24'd0, out_data}, 32'h08);
        wait_resp(1);
        chk("add_pulses", pulses - p0, 32'd1);

        // SUB then AND back-to-back
        p0 = pulses;
        send_frame(8'h02, 8'h05, 8'h07, 8'hFE, 1'b0);
        send_frame(8'h01, 8'hF0, 8'h3C, 8'h30, 1'b0);
        wait_resp(3);
        chk("b2b_pulses", pulses - p0, 32'd2);

        // Illegal opcode, then XOR
        p0 = pulses;
        send_frame(8'h07, 8'hAA, 8'h55, 8'h00, 1'b1);
        chk("ill_ov_now", {31'd0, out_valid}, 32'd1);
        chk("ill_cv", {31'd0, cmd_valid}, 32'd0);
        chk("ill_err_count", {30'd0, err_count}, 32'd1);
        wait_resp(4);
        chk("ill_pulses", pulses - p0, 32'd0);
        send_frame(8'h03, 8'hFF, 8'h0F, 8'hF0, 1'b0);
        wait_resp(5);

        // Backpressure with a pending input byte
        out_ready = 1'b0;
        send_frame(8'h06, 8'h80, 8'h01, 8'h81, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 8'h04;
        for (int i = 0; i < 10; i++) begin
            chk("bp_ov", {31'd0, out_valid}, 32'd1);
            chk("bp_data", {24'd0, out_data}, 32'h81);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release", {31'd0, out_valid}, 32'd0);
        chk("bp_get_op", {31'd0, in_ready}, 32'd1);
        wait_resp(6);

        // Reset after the A byte
        send_byte(8'h04);
        send_byte(8'h11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_cmd", {13'd0, cmd}, 32'd0);
        chk("mid_rst_cv", {31'd0, cmd_valid}, 32'd0);
        chk("mid_rst_ov", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_data", {24'd0, out_data}, 32'd0);
        chk("mid_rst_err", {31'd0, out_err}, 32'd0);
        chk("mid_rst_cnt", {30'd0, err_count}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(8'h04, 8'hFF, 8'h01, 8'h00, 1'b0);
        chk("wrap_cmd", {13'd0, cmd}, 32'h4FF01);
        wait_resp(7);

        // Saturating illegal-opcode counter
        sat_ops[0] = 8'h00;
        sat_ops[1] = 8'h05;
        sat_ops[2] = 8'h07;
        sat_ops[3] = 8'h00;
        sat_ops[4] = 8'h05;
        for (int k = 0; k < 5; k++) begin
            if (exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
            send_frame(sat_ops[k], 8'hAA, 8'h55, 8'h00, 1'b1);
            chk("sat_cnt", {30'd0, err_count}, {30'd0, exp_cnt});
            wait_resp(8 + k);
        end

        repeat (3) @(posedge clk);
        chk("q_left", q_data.size() + q_cmd.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Initiator side of the ALU command interface.
- Accepts a byte-serial frame of three bytes: opcode, operand A, operand B.
- Assembles the packed command (oper[2:0], inA[7:0], inB[7:0]) and drives it to the combinational ALU.
- Captures the ALU result and returns it to the requester over a valid/ready handshake, flagging illegal opcodes.

Parameters:
- ERR_CNT_W, 8, width of the saturating illegal-opcode counter.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input byte valid.
- in_ready  out  1  issuer can accept a byte.
- in_data  in  8  frame byte (opcode, then A, then B).
- cmd  out  19  packed command to ALU: [18:16] oper, [15:8] inA, [7:0] inB.
- cmd_valid  out  1  cmd is being issued this cycle.
- alu_result  in  8  combinational ALU result for cmd.
- out_valid  out  1  response available.
- out_ready  in  1  requester accepts response.
- out_data  out  8  captured result (0x00 on error).
- out_err  out  1  response corresponds to an illegal opcode.
- err_count  out  ERR_CNT_W  number of illegal-opcode frames seen, saturating.

Behaviour:
- Opcode encodings (in_data[2:0]):
  - ADD = 3'b100, SUB = 3'b010, AND = 3'b001, OR = 3'b110, XOR = 3'b011.
  - 3'b000, 3'b101 and 3'b111 are illegal.
  - in_data[7:3] of the opcode byte is ignored.
- A byte transfer happens on a rising edge with in_valid & in_ready. A response transfer happens on a rising edge with out_valid & out_ready.
- FSM states and transitions:
  - GET_OP: in_ready=1. On transfer, latch opcode and legality, go to GET_A.
  - GET_A: in_ready=1. On transfer, latch A, go to GET_B.
  - GET_B: in_ready=1. On transfer, latch B. Go to ISSUE if the opcode is legal, else go to RESP with out_err=1, out_data=0x00, and err_count incremented.
  - ISSUE: exactly one cycle. in_ready=0, cmd_valid=1. At the end of the cycle, alu_result is registered into out_data with out_err=0. Go to RESP.
  - RESP: out_valid=1, in_ready=0. out_data and out_err are held stable until transfer. On transfer, go to GET_OP.
- Illegal frames still consume all three bytes so that framing is preserved. No cmd_valid pulse is generated for an illegal frame.
- cmd is registered and holds the last latched fields in every state. Only cmd_valid qualifies it.
- Latency, legal frame: B byte accepted on edge N; ISSUE during cycle N..N+1; out_valid high from edge N+1.
- Latency, illegal frame: out_valid high from edge N.
- Minimum frame period without backpressure is 5 cycles (3 byte cycles + ISSUE + RESP).
- in_valid low in any GET_* state: the FSM stays in that state indefinitely, with no timeout.
- out_ready low in RESP: the FSM stalls, out_* is held, and no input is accepted.
- Arithmetic: the ALU result is 8-bit modulo 2^8. The issuer performs no widening and propagates no carry or borrow.
- err_count saturates at 2^ERR_CNT_W-1 and does not wrap.
- Reset (asynchronous, at any point including mid-frame or mid-response):
  - State returns to GET_OP.
  - in_ready=1 while in GET_OP.
  - cmd=0, cmd_valid=0, out_valid=0, out_data=0x00, out_err=0, err_count=0.
  - Any partial frame is discarded.

Test Plan:
- ADD frame 0x04,0x03,0x05 with out_ready=1 -> one cmd_valid pulse with cmd=19'h40305; out_data=0x08, out_err=0; out_valid rises one edge after the B byte is accepted.
- SUB frame 0x02,0x05,0x07 then AND frame 0x01,0xF0,0x3C back-to-back -> out_data=0xFE then 0x30; cmd_valid pulses exactly twice; in_ready low during ISSUE and RESP.
- Illegal opcode 0x07,0xAA,0x55 -> no cmd_valid pulse; out_err=1, out_data=0x00, err_count=1. A following legal XOR frame 0x03,0xFF,0x0F -> 0xF0 with out_err=0.
- Backpressure: OR frame 0x06,0x80,0x01 with out_ready held low 10 cycles -> out_valid=1 and out_data=0x81 stable throughout; in_ready=0; no byte is consumed even with in_valid=1. Response completes on the first out_ready edge.
- Reset asserted after the A byte of a frame (opcode 0x04, A 0x11) -> all outputs return to their reset values. A new frame 0x04,0xFF,0x01 -> out_data=0x00 (wrap), with no contamination from 0x11.
- Set ERR_CNT_W=2 and send 5 illegal frames (opcodes 0x00, 0x05, 0x07, 0x00, 0x05) -> err_count reads 1,2,3,3,3.
